// File: rtl/antitheft_dspl_fmt_if.sv
// Bundle between the anti-theft FSM, this display formatter and the 8-digit display driver.
// Digit words are {en, hex[3:0], dp}, with d1 the leftmost digit.
interface antitheft_dspl_fmt_if;
    logic [2:0] state_code;
    logic       load;
    logic [6:0] load_val;
    logic       pause;
    logic       alarm;
    logic       running;
    logic       expired;
    logic [5:0] d1;
    logic [5:0] d2;
    logic [5:0] d3;
    logic [5:0] d4;
    logic [5:0] d5;
    logic [5:0] d6;
    logic [5:0] d7;
    logic [5:0] d8;

    modport master (
        output state_code, load, load_val, pause, alarm,
        input  running, expired, d1, d2, d3, d4, d5, d6, d7, d8
    );

    modport slave (
        input  state_code, load, load_val, pause, alarm,
        output running, expired, d1, d2, d3, d4, d5, d6, d7, d8
    );
endinterface

// File: rtl/antitheft_dspl_fmt.sv
// Anti-theft display formatter: BCD 0-99 s countdown, state-code digit, heartbeat
// point and alarm blink, producing eight registered digit words for the display driver.
module antitheft_dspl_fmt #(
    parameter int SEC_CYCLES   = 100_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic           clock,
    input  logic           reset,
    antitheft_dspl_fmt_if.slave bus
);
    localparam int PW = $clog2(SEC_CYCLES);
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [3:0]    r_tens;
    logic [3:0]    r_units;
    logic [PW-1:0] r_presc;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic          r_expired;

    logic [3:0]    w_tens_nx;
    logic [3:0]    w_units_nx;
    logic [PW-1:0] w_presc_nx;
    logic          w_expired_nx;
    logic [6:0]    w_load_sat;
    logic [7:0]    w_load_bcd;
    logic          w_nonzero;
    logic          w_running;
    logic          w_tick;
    logic          w_hb;
    logic          w_gate;

    // Repeated subtraction keeps the binary-to-BCD split free of a divider.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        logic [6:0] rem;
        logic [3:0] t;
        rem = v;
        t   = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (rem >= 7'd10) begin
                rem = rem - 7'd10;
                t   = t + 4'd1;
            end else begin
                rem = rem;
            end
        end
        return {t, rem[3:0]};
    endfunction

    assign w_load_sat  = (bus.load_val > 7'd99) ? 7'd99 : bus.load_val;
    assign w_load_bcd  = bin_to_bcd(w_load_sat);
    assign w_nonzero   = (r_tens != 4'd0) || (r_units != 4'd0);
    assign w_running   = w_nonzero && !bus.pause;
    assign w_tick      = w_running && (r_presc == PW'(SEC_CYCLES - 1));
    assign w_hb        = w_running && (r_presc < PW'(SEC_CYCLES / 2));
    assign w_gate      = bus.alarm ? r_blink_phase : 1'b1;
    assign bus.running = w_running;
    assign bus.expired = r_expired;

    // Next countdown/prescaler state; load beats a coincident tick and never expires.
    always_comb begin
        w_tens_nx    = r_tens;
        w_units_nx   = r_units;
        w_presc_nx   = r_presc;
        w_expired_nx = 1'b0;
        if (bus.load) begin
            w_tens_nx  = w_load_bcd[7:4];
            w_units_nx = w_load_bcd[3:0];
            w_presc_nx = '0;
        end else if (w_tick) begin
            w_presc_nx   = '0;
            w_expired_nx = (r_tens == 4'd0) && (r_units == 4'd1);
            if (r_units != 4'd0) begin
                w_units_nx = r_units - 4'd1;
            end else begin
                w_units_nx = 4'd9;
                w_tens_nx  = r_tens - 4'd1;
            end
        end else if (w_running) begin
            w_presc_nx = r_presc + PW'(1);
        end else begin
            w_presc_nx = r_presc;
        end
    end

    // Countdown, prescaler, expiry pulse and blink phase state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tens        <= 4'd0;
            r_units       <= 4'd0;
            r_presc       <= '0;
            r_expired     <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else begin
            r_tens    <= w_tens_nx;
            r_units   <= w_units_nx;
            r_presc   <= w_presc_nx;
            r_expired <= w_expired_nx;
            // Idle alarm parks the blinker so the next alarm opens in the visible phase.
            if (!bus.alarm) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BW'(1);
            end
        end
    end

    // Registered digit words; blink gating touches only the enable bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.d1 <= 6'b100000;
            bus.d2 <= 6'd0;
            bus.d3 <= 6'd0;
            bus.d4 <= 6'd0;
            bus.d5 <= 6'd0;
            bus.d6 <= 6'b100000;
            bus.d7 <= 6'd0;
            bus.d8 <= 6'd0;
        end else begin
            bus.d1 <= {w_gate, 1'b0, bus.state_code, 1'b0};
            bus.d2 <= 6'd0;
            bus.d3 <= 6'd0;
            bus.d4 <= 6'd0;
            bus.d5 <= {w_gate & (r_tens != 4'd0), r_tens, 1'b0};
            bus.d6 <= {w_gate, r_units, w_hb};
            bus.d7 <= 6'd0;
            bus.d8 <= {w_gate & bus.alarm, 4'hA, 1'b0};
        end
    end
endmodule

// File: tb/tb_antitheft_dspl_fmt.sv
// Directed bench for antitheft_dspl_fmt with SEC_CYCLES=10, BLINK_CYCLES=4.
module tb_antitheft_dspl_fmt;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt;

    antitheft_dspl_fmt_if bus ();

    antitheft_dspl_fmt #(.SEC_CYCLES(10), .BLINK_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] val;
        logic [2:0] sc;
        logic [5:0] e_d1;
        logic [5:0] e_d5;
        logic [5:0] e_d6;
        logic       e_run;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [6:0] v);
        bus.load_val = v;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    initial begin
        bus.state_code = 3'd0;
        bus.load       = 1'b0;
        bus.load_val   = 7'd0;
        bus.pause      = 1'b0;
        bus.alarm      = 1'b0;

        vecs[0] = '{7'd12,  3'd1, 6'b100010, 6'b100010, 6'b100101, 1'b1};
        vecs[1] = '{7'd120, 3'd7, 6'b101110, 6'b110010, 6'b110011, 1'b1};
        vecs[2] = '{7'd100, 3'd2, 6'b100100, 6'b110010, 6'b110011, 1'b1};
        vecs[3] = '{7'd99,  3'd3, 6'b100110, 6'b110010, 6'b110011, 1'b1};
        vecs[4] = '{7'd0,   3'd0, 6'b100000, 6'b000000, 6'b100000, 1'b0};
        vecs[5] = '{7'd5,   3'd4, 6'b101000, 6'b000000, 6'b101011, 1'b1};
        vecs[6] = '{7'd10,  3'd6, 6'b101100, 6'b100010, 6'b100001, 1'b1};
        vecs[7] = '{7'd127, 3'd5, 6'b101010, 6'b110010, 6'b110011, 1'b1};
        vecs[8] = '{7'd40,  3'd0, 6'b100000, 6'b101000, 6'b100001, 1'b1};

        // Reset state
        step();
        chk("rst_d1", 8'(bus.d1), 8'b100000);
        chk("rst_d2", 8'(bus.d2), 8'd0);
        chk("rst_d5", 8'(bus.d5), 8'd0);
        chk("rst_d6", 8'(bus.d6), 8'b100000);
        chk("rst_d8", 8'(bus.d8), 8'd0);
        chk("rst_running", 8'(bus.running), 8'd0);
        chk("rst_expired", 8'(bus.expired), 8'd0);
        reset = 1'b0;

        // Load / mapping table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            bus.state_code = vecs[i].sc;
            do_load(vecs[i].val);
            step();
            chk($sformatf("v%0d_d1", i), 8'(bus.d1), 8'(vecs[i].e_d1));
            chk($sformatf("v%0d_d5", i), 8'(bus.d5), 8'(vecs[i].e_d5));
            chk($sformatf("v%0d_d6", i), 8'(bus.d6), 8'(vecs[i].e_d6));
            chk($sformatf("v%0d_blank", i), 8'(bus.d2 | bus.d3 | bus.d4 | bus.d7), 8'd0);
            chk($sformatf("v%0d_d8", i), 8'(bus.d8), 8'b010100);
            chk($sformatf("v%0d_running", i), 8'(bus.running), 8'(vecs[i].e_run));
            chk($sformatf("v%0d_expired", i), 8'(bus.expired), 8'd0);
        end

        // Full countdown from 12
        bus.state_code = 3'd0;
        do_reset();
        do_load(7'd12);
        exp_cnt = 0;
        for (int i = 1; i <= 121; i++) begin
            step();
            if (i < 120) exp_cnt += int'(bus.expired);
            if (i == 11) begin
                chk("cd_d6_at11", 8'(bus.d6), 8'b100011);
                chk("cd_d5_at11", 8'(bus.d5), 8'b100010);
            end
            if (i == 119) begin
                chk("cd_early_expired", 8'(exp_cnt), 8'd0);
                chk("cd_d5_blank", 8'(bus.d5), 8'd0);
                chk("cd_d6_01", 8'(bus.d6), 8'b100010);
                chk("cd_running_01", 8'(bus.running), 8'd1);
            end
            if (i == 120) begin
                chk("cd_expired_pulse", 8'(bus.expired), 8'd1);
                chk("cd_running_00", 8'(bus.running), 8'd0);
            end
            if (i == 121) begin
                chk("cd_expired_drop", 8'(bus.expired), 8'd0);
                chk("cd_d6_00", 8'(bus.d6), 8'b100000);
            end
        end
        exp_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            exp_cnt += int'(bus.expired);
        end
        chk("cd_no_repeat_expiry", 8'(exp_cnt), 8'd0);

        // Load coinciding with a tick
        do_reset();
        do_load(7'd12);
        for (int i = 0; i < 9; i++) step();
        do_load(7'd5);
        step();
        chk("ldtick_d6", 8'(bus.d6), 8'b101011);
        chk("ldtick_d5", 8'(bus.d5), 8'd0);

        // Pause mid-count retains the prescaler
        do_reset();
        do_load(7'd12);
        for (int i = 0; i < 5; i++) step();
        bus.pause = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (i == 2) begin
                chk("pause_running", 8'(bus.running), 8'd0);
                chk("pause_d6", 8'(bus.d6), 8'b100100);
            end
        end
        chk("pause_d5_held", 8'(bus.d5), 8'b100010);
        chk("pause_d6_held", 8'(bus.d6), 8'b100100);
        bus.pause = 1'b0;
        #1;
        chk("resume_running", 8'(bus.running), 8'd1);
        for (int i = 0; i < 5; i++) step();
        chk("resume_pre_tick", 8'(bus.d6), 8'b100100);
        step();
        chk("resume_tick", 8'(bus.d6), 8'b100011);

        // Alarm blink
        bus.state_code = 3'd5;
        do_reset();
        bus.alarm = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic vis;
            step();
            vis = ((k / 4) % 2) == 0;
            chk($sformatf("blink%0d_d1", k), 8'(bus.d1), vis ? 8'b101010 : 8'b001010);
            chk($sformatf("blink%0d_d8", k), 8'(bus.d8), vis ? 8'b110100 : 8'b010100);
            chk($sformatf("blink%0d_d6", k), 8'(bus.d6), vis ? 8'b100000 : 8'b000000);
        end
        bus.alarm = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("steady%0d_d1", k), 8'(bus.d1), 8'b101010);
            chk($sformatf("steady%0d_d8", k), 8'(bus.d8), 8'b010100);
        end

        // Reset mid-countdown at 03
        bus.state_code = 3'd2;
        do_reset();
        do_load(7'd3);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        chk("midrst_d1", 8'(bus.d1), 8'b100000);
        chk("midrst_d5", 8'(bus.d5), 8'd0);
        chk("midrst_d6", 8'(bus.d6), 8'b100000);
        chk("midrst_expired", 8'(bus.expired), 8'd0);
        chk("midrst_running", 8'(bus.running), 8'd0);
        reset = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            exp_cnt += int'(bus.expired);
        end
        chk("midrst_no_expiry", 8'(exp_cnt), 8'd0);
        chk("midrst_d6_after", 8'(bus.d6), 8'b100000);

        // Loading 0 over a running count
        do_load(7'd7);
        for (int i = 0; i < 3; i++) step();
        do_load(7'd0);
        exp_cnt = int'(bus.expired);
        for (int i = 0; i < 20; i++) begin
            step();
            exp_cnt += int'(bus.expired);
        end
        chk("load0_no_expiry", 8'(exp_cnt), 8'd0);
        chk("load0_d6", 8'(bus.d6), 8'b100000);
        chk("load0_running", 8'(bus.running), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/antitheft_dspl_fmt.md
Name: antitheft_dspl_fmt

Overview:
Display formatter for the anti-theft system. Holds a 0–99 s BCD countdown (entry/exit delay), tracks the system state code, and produces the eight 6-bit digit words consumed by the 8-digit multiplexed display driver. Sits between the anti-theft FSM and the display driver. Every digit output is registered.

Parameters:
SEC_CYCLES, 100_000_000, clock cycles per countdown second (must be ≥ 2)
BLINK_CYCLES, 25_000_000, clock cycles per blink half-period (must be ≥ 1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
state_code  in  3  current FSM state, shown as a hex digit
load  in  1  single-cycle pulse: load countdown from load_val
load_val  in  7  countdown seconds, binary; values >99 saturate to 99
pause  in  1  level: freezes countdown and prescaler
alarm  in  1  level: blinks all enabled digits
running  out  1  countdown active: count ≠ 0 and not paused
expired  out  1  one-cycle pulse when the count reaches 0 by decrement
d1..d8  out  6 each  digit word {en, hex[3:0], dp}; en=1 lights the digit, dp=1 lights the point; d1 is leftmost

Behaviour:
- Digit-word format: bit5 = enable, bits4:1 = hex value, bit0 = decimal point. All control bits are active-high.
- Registers: tens[3:0] and units[3:0] (BCD), prescaler (0..SEC_CYCLES-1), blink counter (0..BLINK_CYCLES-1), blink_phase, and all d1..d8.
- Reset values:
  - tens = units = 0; prescaler = 0; blink counter = 0; blink_phase = 1 (visible).
  - expired = 0; running = 0.
  - d1 = 6'b100000; d6 = 6'b100000; d2, d3, d4, d5, d7, d8 = 0.
- Load (highest priority after reset):
  - v = min(load_val, 99); tens = v/10; units = v%10; prescaler cleared.
  - Load overrides a simultaneous tick or expiry.
  - Loading 0 produces no expired pulse.
- Prescaler:
  - Increments each cycle while count ≠ 0 and pause = 0.
  - At SEC_CYCLES-1 it wraps to 0 and issues a tick.
  - Held at its current value while paused or while count = 0.
- Tick: BCD decrement.
  - If units ≠ 0: units−1.
  - Otherwise: units = 9, tens−1.
  - The count never wraps below 00.
- Expiry: expired = 1 for exactly the one cycle in which the registered count is first 00 after a decrement from 01.
- running: combinational from the registers, (tens|units) ≠ 0 && !pause.
- Blink:
  - The blink counter runs continuously.
  - At BLINK_CYCLES-1 it wraps and toggles blink_phase.
  - While alarm = 0, blink_phase is forced to 1 and the counter is cleared, so a new alarm starts in the visible phase.
- Digit mapping (computed from the current registers and inputs, registered, so 1-cycle latency):
  - d1 = {1, 0, state_code, 0}
  - d2, d3, d4 = 0 (blank)
  - d5 = {tens≠0, tens, 0} (leading zero blanked)
  - d6 = {1, units, hb}, where hb = running && prescaler < SEC_CYCLES/2 (heartbeat point)
  - d7 = 0
  - d8 = {alarm, 4'hA, 0} (shows "A" while alarming)
- Blink gating: when alarm = 1, the en bit of every digit is ANDed with blink_phase. All other bits are unchanged.
- Pause during a tick cycle: no tick occurs.
- Reset mid-countdown: everything returns to reset values on the next edge, and no expired pulse is generated.

Test Plan:
- Reset, with SEC_CYCLES=10 and BLINK_CYCLES=4: d1=6'b100000, d6=6'b100000, all other d=0, running=0, expired=0.
- load_val=12 pulse → two cycles later d5={1,1,0}, d6={1,2,x}; after 10 cycles, units=1; after 120 cycles, count 00 with a single expired pulse; d5 blanks once tens=0.
- load_val=120 → count shows 99; load during a tick cycle with load_val=5 → count 05, no decrement applied that cycle.
- pause=1 for 25 cycles mid-count → count and prescaler frozen, running=0, d6 dp=0; release → count resumes with the prescaler value retained.
- alarm=1 → all enabled en bits toggle every 4 cycles, starting visible; d8=6'b110100 in visible phases; alarm=0 → steady display.
- Countdown at 03 with reset asserted → next cycle count 00, expired stays 0, d outputs at reset values.
